// File: rtl/light_seq_monitor.sv
// light_seq_monitor
//   Watches the six lamp drives of the traffic-light controller, rebuilds the
//   current phase from them through a stability filter, measures each phase's
//   length in 1 s ticks and raises sticky flags for illegal lamp codes,
//   simultaneous greens and out-of-sequence phase transitions.
//
// Ports
//   clk, rst         system clock, synchronous active-high reset
//   tick             one-cycle 1 s pulse
//   R1 Y1 G1 R2 Y2 G2 lamp drives (clk domain)
//   clr_err          clears the sticky error flags (a same-cycle set wins)
//   phase            accepted phase code
//   dur_out          tick count of the last completed phase (saturating)
//   dur_phase        phase code dur_out belongs to
//   dur_valid        one-cycle pulse when dur_out/dur_phase update
//   err_illegal      sticky: illegal lamp code accepted
//   err_conflict     sticky: G1 and G2 both lit
//   err_order        sticky: accepted transition breaks the sequence

module light_seq_monitor #(
  parameter int unsigned CNT_WIDTH  = 11,
  parameter int unsigned STABLE_CYC = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 R1,
  input  logic                 Y1,
  input  logic                 G1,
  input  logic                 R2,
  input  logic                 Y2,
  input  logic                 G2,
  input  logic                 clr_err,
  output logic [2:0]           phase,
  output logic [CNT_WIDTH-1:0] dur_out,
  output logic [2:0]           dur_phase,
  output logic                 dur_valid,
  output logic                 err_illegal,
  output logic                 err_conflict,
  output logic                 err_order
);

  typedef enum logic [2:0] {
    PhNight   = 3'd0,
    PhG1      = 3'd1,
    PhG1to2   = 3'd2,
    PhG2      = 3'd3,
    PhG2to1   = 3'd4,
    PhUnknown = 3'd6,
    PhIllegal = 3'd7
  } phase_e;

  localparam int unsigned StabW = (STABLE_CYC < 1) ? 1 : $clog2(STABLE_CYC + 1);
  localparam logic [StabW-1:0]     StabMax = StabW'(STABLE_CYC);
  localparam logic [CNT_WIDTH-1:0] CntMax  = '1;

  logic [5:0]           samp;   // {R1,Y1,G1,R2,Y2,G2}
  phase_e               dec;
  phase_e               cand;
  phase_e               cand_d;
  phase_e               phase_q;
  logic [StabW-1:0]     stab;
  logic [StabW-1:0]     stab_d;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 accept;
  logic                 legal;
  logic                 conflict;

  always_comb begin
    case (samp)
      6'b010010: dec = PhNight;
      6'b001100: dec = PhG1;
      6'b010100: dec = PhG1to2;
      6'b100001: dec = PhG2;
      6'b100010: dec = PhG2to1;
      default:   dec = PhIllegal;
    endcase
  end

  // Run-length filter; the stability count saturates so a code that stays put
  // is evaluated for acceptance every cycle. Acceptance looks at the next-state
  // count so the phase updates on the same edge the count reaches STABLE_CYC.
  always_comb begin
    cand_d = cand;
    stab_d = stab;
    if (dec != cand) begin
      cand_d = dec;
      stab_d = StabW'(1);
    end else if (stab != StabMax) begin
      stab_d = stab + 1'b1;
    end
  end

  assign accept = (stab_d == StabMax) && (cand_d != phase_q);

  // NIGHT is reachable from anywhere; after reset (UNKNOWN) anything goes.
  always_comb begin
    legal = 1'b0;
    if ((phase_q == PhUnknown) || (cand_d == PhNight)) begin
      legal = 1'b1;
    end else begin
      case (phase_q)
        PhNight: legal = (cand_d == PhG1);
        PhG1:    legal = (cand_d == PhG1to2);
        PhG1to2: legal = (cand_d == PhG2);
        PhG2:    legal = (cand_d == PhG2to1);
        PhG2to1: legal = (cand_d == PhG1);
        default: legal = 1'b0;
      endcase
    end
  end

  // Safety condition, deliberately taken straight from samp without filtering.
  assign conflict = samp[3] & samp[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      samp         <= 6'b000000;
      cand         <= PhIllegal;
      stab         <= '0;
      phase_q      <= PhUnknown;
      cnt          <= '0;
      dur_out      <= '0;
      dur_phase    <= PhUnknown;
      dur_valid    <= 1'b0;
      err_illegal  <= 1'b0;
      err_conflict <= 1'b0;
      err_order    <= 1'b0;
    end else begin
      samp         <= {R1, Y1, G1, R2, Y2, G2};
      cand         <= cand_d;
      stab         <= stab_d;
      dur_valid    <= 1'b0;
      err_conflict <= conflict | (err_conflict & ~clr_err);
      err_illegal  <= (accept && (cand_d == PhIllegal)) | (err_illegal & ~clr_err);
      err_order    <= (accept && !legal) | (err_order & ~clr_err);
      if (accept) begin
        phase_q <= cand_d;
        cnt     <= '0;  // a tick landing here is dropped
        // Time spent in UNKNOWN is partial, so it is not reported.
        if (phase_q != PhUnknown) begin
          dur_valid <= 1'b1;
          dur_out   <= cnt;
          dur_phase <= phase_q;
        end
      end else if (tick && (cnt != CntMax)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign phase = phase_q;

endmodule

// File: doc/light_seq_monitor.md
# light_seq_monitor

Observes the six lamp drive signals (R1 Y1 G1 R2 Y2 G2) produced by the traffic-light controller and reconstructs the current phase from them. It measures each phase's duration in 1 s ticks and flags illegal lamp combinations, simultaneous greens and out-of-order phase transitions. It sits beside the controller on the same clock, either as a self-check block on the board or as a bench checker, and consumes the same 1 s pulse the controller counts down on.

## Interface
- CNT_WIDTH, 11, width of duration counter and dur_out
- STABLE_CYC, 4, consecutive cycles a new lamp code must hold before acceptance (≥1)
- clk  in  1  system clock (12 MHz on board)
- rst  in  1  synchronous, active-high reset
- tick  in  1  one-cycle 1 s pulse, synchronous to clk
- R1, Y1, G1, R2, Y2, G2  in  1 each  lamp drives, clk domain
- clr_err  in  1  clears sticky error flags
- phase  out  3  accepted phase code
- dur_out  out  CNT_WIDTH  tick count of last completed phase
- dur_phase  out  3  phase code that dur_out belongs to
- dur_valid  out  1  one-cycle pulse, dur_out/dur_phase updated
- err_illegal  out  1  sticky: illegal lamp code accepted
- err_conflict  out  1  sticky: G1 and G2 both high
- err_order  out  1  sticky: transition violates the sequence

## Operation
- Phase codes (lamps listed as {R1,Y1,G1,R2,Y2,G2}):
  - NIGHT=0 (010010)
  - G1=1 (001100)
  - G1TO2=2 (010100)
  - G2=3 (100001)
  - G2TO1=4 (100010)
  - UNKNOWN=6
  - ILLEGAL=7 (any other pattern)
- Input stage: the six lamps are registered once into samp; the decoder operates on samp.
- Filter: cand holds the last decoded code, and stab counts consecutive cycles that decode(samp) equals cand.
  - If the decode differs from cand: cand ← the new code, stab ← 1.
  - When stab reaches STABLE_CYC and cand ≠ phase, cand is accepted: phase ← cand.
- Legal accepted transitions:
  - G1→G1TO2→G2→G2TO1→G1.
  - Any phase→NIGHT.
  - NIGHT→G1.
  - UNKNOWN→any code.
  - Any other transition sets err_order, including X→ILLEGAL and ILLEGAL→X.
- Acceptance of ILLEGAL sets err_illegal. The phase becomes 7 and sequencing is not checked again until the next transition out of it.
- err_conflict is set the cycle after samp has G1=G2=1. It is unfiltered because it is the safety condition.
- Duration counter cnt:
  - Increments on tick and saturates at all-ones.
  - On acceptance of a new phase:
    - dur_out ← cnt, dur_phase ← old phase, dur_valid=1 for one cycle, cnt ← 0.
    - A tick in the acceptance cycle is dropped.
  - No dur_valid is issued when the old phase is UNKNOWN, because that duration is partial.
- Sticky flags: clr_err clears all three. If a set and clr_err occur in the same cycle, the set wins.

## Timing
- Reset values:
  - phase=6 (UNKNOWN), dur_phase=6
  - dur_out=0, dur_valid=0, cnt=0
  - all err_* = 0
  - samp=0, cand=ILLEGAL (samp=0 decodes ILLEGAL), stab=0
- Latency from a lamp pin change (held steady) to phase update is STABLE_CYC+1 clk edges. dur_valid is asserted in the same cycle phase changes.
- A glitch shorter than STABLE_CYC cycles is never accepted. It neither changes phase nor resets cnt.
- err_conflict asserts 2 edges after the pin event; err_illegal and err_order assert with the accepted phase change.
- Reset mid-phase discards cnt. After reset, the first accepted phase produces no dur_valid and no err_order.

## Test plan
1. Reset, then hold 010010 (NIGHT) → phase=0 after 5 edges; no dur_valid; err_*=0.
2. Drive a legal cycle with 8 ticks in G1, 6 in G1TO2, 8 in G2 and 6 in G2TO1 → dur_valid pulses report (dur_phase,dur_out) = (1,8),(2,6),(3,8),(4,6); no errors.
3. During G1, apply a 3-cycle glitch to 010100 → phase stays 1, cnt unaffected, no dur_valid.
4. Go G1→G2 directly, holding 100001 for ≥4 cycles → err_order=1 and phase=3; pulse clr_err → flags return to 0.
5. Drive 001001 for 1 cycle → err_conflict=1 two edges later; drive 111111 for 4 cycles → err_illegal=1 and phase=7.
6. Stay in G2 for 2^CNT_WIDTH+5 ticks → dur_out=2047 (saturated) on the next transition; assert clr_err together with a new conflict → err_conflict remains 1.
